// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic        memtoreg;
    logic        regwrite;
    logic [4:0]  rd;
  } mem_wb_t;

  // NOP inserted into MEM/WB on stall, misalignment or bus abort
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

  // Access width from funct3; anything unrecognised is a word access
  function automatic mem_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/half of the read word
// and sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  // lane select and extension
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half   = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    // bu/hu have funct3[2] set; the signed forms do not
    w_signed = ~i_funct3[2];
    case (f3_size(i_funct3))
      SZ_B:    o_data = {{24{w_signed & w_byte[7]}}, w_byte};
      SZ_H:    o_data = {{16{w_signed & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the req/ack data bus, stalls the pipeline
// while an access is outstanding, and registers results into MEM/WB.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] EX_MEM_ALU_result,
  input  logic [31:0] EX_MEM_rs2_data,
  input  logic [2:0]  EX_MEM_funct3,
  input  logic        EX_MEM_memread,
  input  logic        EX_MEM_memwrite,
  input  logic        EX_MEM_memtoreg,
  input  logic        EX_MEM_regwrite,
  input  logic [4:0]  EX_MEM_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        MEM_stall,
  output logic        MEM_misaligned,
  output logic        MEM_bus_error,
  output logic [31:0] MEM_WB_ALU_result,
  output logic [31:0] MEM_WB_mem_data,
  output logic        MEM_WB_memtoreg,
  output logic        MEM_WB_regwrite,
  output logic [4:0]  MEM_WB_rd
);

  // keep at least one counter bit when the timeout is disabled
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  mem_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  mem_wb_t       r_wb;
  logic          r_misaligned;
  logic          r_bus_error;

  logic          w_access;
  logic          w_store;
  mem_size_e     w_size;
  logic [1:0]    w_ofs;
  logic          w_misaligned;
  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic          w_issue;
  logic          w_timeout;
  logic          w_done;
  logic [31:0]   w_ld_data;
  mem_wb_t       w_wb_nxt;

  mem_load_align u_align (
    .i_funct3  (EX_MEM_funct3),
    .i_addr_lo (EX_MEM_ALU_result[1:0]),
    .i_rdata   (dmem_rdata),
    .o_data    (w_ld_data)
  );

  // decode access type, alignment and store lanes from EX/MEM
  always_comb begin
    w_access = EX_MEM_memread | EX_MEM_memwrite;
    w_store  = EX_MEM_memwrite;   // store wins if both are set
    w_size   = f3_size(EX_MEM_funct3);
    w_ofs    = EX_MEM_ALU_result[1:0];
    case (w_size)
      SZ_B:    w_misaligned = 1'b0;
      SZ_H:    w_misaligned = w_ofs[0];
      default: w_misaligned = |w_ofs;
    endcase
    w_misaligned = w_misaligned & w_access;
    w_wdata = EX_MEM_rs2_data;
    w_be    = 4'b1111;
    if (w_store) begin
      case (w_size)
        SZ_B: begin
          w_wdata = {4{EX_MEM_rs2_data[7:0]}};
          w_be    = 4'b0001 << w_ofs;
        end
        SZ_H: begin
          w_wdata = {2{EX_MEM_rs2_data[15:0]}};
          w_be    = 4'b0011 << {w_ofs[1], 1'b0};
        end
        default: begin
          w_wdata = EX_MEM_rs2_data;
          w_be    = 4'b1111;
        end
      endcase
    end
  end

  // bus request, stall and completion; WAIT drives the captured bus fields
  always_comb begin
    w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == ST_WAIT) && !dmem_ack &&
                (r_cnt == CW'(TIMEOUT_CYCLES));
    w_issue   = (r_state == ST_IDLE) && w_access && !w_misaligned;
    dmem_req  = !reset && (w_issue || ((r_state == ST_WAIT) && !w_timeout));
    if (r_state == ST_WAIT) begin
      dmem_we    = r_we;
      dmem_addr  = r_addr;
      dmem_wdata = r_wdata;
      dmem_be    = r_be;
    end else begin
      dmem_we    = w_store;
      dmem_addr  = {EX_MEM_ALU_result[31:2], 2'b00};
      dmem_wdata = w_wdata;
      dmem_be    = w_be;
    end
    w_done    = dmem_req && dmem_ack;
    MEM_stall = dmem_req && !dmem_ack;
  end

  // next MEM/WB contents: pass-through, completed access, or bubble
  always_comb begin
    w_wb_nxt = MEM_WB_BUBBLE;
    if ((r_state == ST_IDLE) && !w_access) begin
      w_wb_nxt.alu_result = EX_MEM_ALU_result;
      w_wb_nxt.memtoreg   = EX_MEM_memtoreg;
      w_wb_nxt.regwrite   = EX_MEM_regwrite;
      w_wb_nxt.rd         = EX_MEM_rd;
    end else if (w_done) begin
      w_wb_nxt.alu_result = EX_MEM_ALU_result;
      w_wb_nxt.mem_data   = w_store ? 32'd0 : w_ld_data;
      w_wb_nxt.memtoreg   = EX_MEM_memtoreg;
      w_wb_nxt.regwrite   = EX_MEM_regwrite & ~w_store;
      w_wb_nxt.rd         = EX_MEM_rd;
    end
  end

  // FSM: IDLE/WAIT, wait counter and held bus fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue && !dmem_ack) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
            r_we    <= dmem_we;
            r_addr  <= dmem_addr;
            r_wdata <= dmem_wdata;
            r_be    <= dmem_be;
          end
        end
        default: begin
          if (dmem_ack || w_timeout) r_state <= ST_IDLE;
          else                       r_cnt   <= r_cnt + CW'(1);
        end
      endcase
    end
  end

  // MEM/WB register and one-cycle exception pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb         <= MEM_WB_BUBBLE;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_wb         <= w_wb_nxt;
      r_misaligned <= (r_state == ST_IDLE) && w_misaligned;
      r_bus_error  <= w_timeout;
    end
  end

  assign MEM_misaligned    = r_misaligned;
  assign MEM_bus_error     = r_bus_error;
  assign MEM_WB_ALU_result = r_wb.alu_result;
  assign MEM_WB_mem_data   = r_wb.mem_data;
  assign MEM_WB_memtoreg   = r_wb.memtoreg;
  assign MEM_WB_regwrite   = r_wb.regwrite;
  assign MEM_WB_rd         = r_wb.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: hand-computed vector table, reset sequences and
// randomized transactions checked against a behavioural model.
module tb_mem_stage;

  localparam int TO = 4;
  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] EX_MEM_ALU_result = '0;
  logic [31:0] EX_MEM_rs2_data = '0;
  logic [2:0]  EX_MEM_funct3 = '0;
  logic        EX_MEM_memread = 1'b0;
  logic        EX_MEM_memwrite = 1'b0;
  logic        EX_MEM_memtoreg = 1'b0;
  logic        EX_MEM_regwrite = 1'b0;
  logic [4:0]  EX_MEM_rd = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        MEM_stall, MEM_misaligned, MEM_bus_error;
  logic [31:0] MEM_WB_ALU_result, MEM_WB_mem_data;
  logic        MEM_WB_memtoreg, MEM_WB_regwrite;
  logic [4:0]  MEM_WB_rd;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .EX_MEM_ALU_result(EX_MEM_ALU_result), .EX_MEM_rs2_data(EX_MEM_rs2_data),
    .EX_MEM_funct3(EX_MEM_funct3), .EX_MEM_memread(EX_MEM_memread),
    .EX_MEM_memwrite(EX_MEM_memwrite), .EX_MEM_memtoreg(EX_MEM_memtoreg),
    .EX_MEM_regwrite(EX_MEM_regwrite), .EX_MEM_rd(EX_MEM_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .MEM_stall(MEM_stall),
    .MEM_misaligned(MEM_misaligned), .MEM_bus_error(MEM_bus_error),
    .MEM_WB_ALU_result(MEM_WB_ALU_result), .MEM_WB_mem_data(MEM_WB_mem_data),
    .MEM_WB_memtoreg(MEM_WB_memtoreg), .MEM_WB_regwrite(MEM_WB_regwrite),
    .MEM_WB_rd(MEM_WB_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu, rs2;
    logic [2:0]  f3;
    logic        rd_en, wr, m2r, rw;
    logic [4:0]  rd;
    logic [31:0] rdata;
  } txn_t;

  typedef struct {
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        misal, tmo;
    logic [31:0] wb_alu, wb_data;
    logic        wb_m2r, wb_rw;
    logic [4:0]  wb_rd;
  } exp_t;

  typedef struct {
    string tag;
    txn_t  t;
    int    delay;
    exp_t  e;
  } vec_t;

  vec_t vecs[NV];

  task automatic chk(input string tag, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  task automatic drive(input txn_t t);
    EX_MEM_ALU_result = t.alu;
    EX_MEM_rs2_data   = t.rs2;
    EX_MEM_funct3     = t.f3;
    EX_MEM_memread    = t.rd_en;
    EX_MEM_memwrite   = t.wr;
    EX_MEM_memtoreg   = t.m2r;
    EX_MEM_regwrite   = t.rw;
    EX_MEM_rd         = t.rd;
  endtask

  // Reference: access rules expressed with plain arithmetic on size/offset.
  // A request is stalled in its first cycle plus up to TO wait cycles, so
  // an ack later than cycle TO+1 never arrives in time.
  function automatic exp_t model(input txn_t t, input int delay);
    exp_t e;
    int sz, ofs;
    logic [31:0] v;
    bit acc, st, sgn;
    e = '{default: '0};
    acc = t.rd_en || t.wr;
    st  = t.wr;
    case (t.f3)
      3'b000, 3'b100: sz = 1;
      3'b001, 3'b101: sz = 2;
      default:        sz = 4;
    endcase
    sgn = (t.f3 == 3'b000) || (t.f3 == 3'b001);
    ofs = int'(t.alu % 4);
    e.misal = acc && ((ofs % sz) != 0);
    e.req   = acc && !e.misal;
    e.we    = st;
    e.addr  = t.alu - 32'(ofs);
    if (st) begin
      if (sz == 1)      e.wdata = {4{t.rs2[7:0]}};
      else if (sz == 2) e.wdata = {2{t.rs2[15:0]}};
      else              e.wdata = t.rs2;
      e.be = 4'(((2 ** sz) - 1) << ofs);
    end else begin
      e.be = 4'hF;
    end
    e.tmo = e.req && (delay > TO + 1);
    if (!e.misal && !e.tmo) begin
      e.wb_alu = t.alu;
      e.wb_m2r = t.m2r;
      e.wb_rd  = t.rd;
      e.wb_rw  = t.rw && !st;
      if (acc && !st) begin
        v = t.rdata >> (8 * ofs);
        if (sz == 1)      e.wb_data = (sgn && v[7])  ? ((v & 32'hFF)   | 32'hFFFFFF00) : (v & 32'hFF);
        else if (sz == 2) e.wb_data = (sgn && v[15]) ? ((v & 32'hFFFF) | 32'hFFFF0000) : (v & 32'hFFFF);
        else              e.wb_data = t.rdata;
      end
    end
    return e;
  endfunction

  // Present one EX/MEM instruction, act as memory acking after `delay`
  // cycles, and check bus/stall each cycle and MEM/WB at the end.
  task automatic run_txn(input string tag, input txn_t t, input int delay, input exp_t e);
    bit done_c, abort_c, stall_c, fin;
    fin = 0;
    drive(t);
    for (int c = 0; c < 16 && !fin; c++) begin
      done_c  = e.req && !e.tmo && (c == delay);
      abort_c = e.req && e.tmo && (c == TO + 1);
      stall_c = e.req && !done_c && !abort_c;
      dmem_ack   = done_c;
      dmem_rdata = done_c ? t.rdata : $urandom;
      #1;
      chk(tag, "req", 32'(dmem_req), 32'(e.req && !abort_c));
      if (e.req && !abort_c) begin
        chk(tag, "we", 32'(dmem_we), 32'(e.we));
        chk(tag, "addr", dmem_addr, e.addr);
        chk(tag, "be", 32'(dmem_be), 32'(e.be));
        if (e.we) chk(tag, "wdata", dmem_wdata, e.wdata);
      end
      chk(tag, "stall", 32'(MEM_stall), 32'(stall_c));
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      if (stall_c) begin
        chk(tag, "bubble_rw", 32'(MEM_WB_regwrite), 32'd0);
        chk(tag, "bubble_rd", 32'(MEM_WB_rd), 32'd0);
        chk(tag, "bubble_pulse", 32'({MEM_misaligned, MEM_bus_error}), 32'd0);
      end else begin
        fin = 1;
      end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s.complete: got no completion after 16 cycles, expected completion", tag);
    end
    chk(tag, "misaligned", 32'(MEM_misaligned), 32'(e.misal));
    chk(tag, "bus_error", 32'(MEM_bus_error), 32'(e.tmo));
    chk(tag, "wb_alu", MEM_WB_ALU_result, e.wb_alu);
    chk(tag, "wb_data", MEM_WB_mem_data, e.wb_data);
    chk(tag, "wb_m2r", 32'(MEM_WB_memtoreg), 32'(e.wb_m2r));
    chk(tag, "wb_rw", 32'(MEM_WB_regwrite), 32'(e.wb_rw));
    chk(tag, "wb_rd", 32'(MEM_WB_rd), 32'(e.wb_rd));
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, "req", 32'(dmem_req), 32'd0);
    chk(tag, "stall", 32'(MEM_stall), 32'd0);
    chk(tag, "pulses", 32'({MEM_misaligned, MEM_bus_error}), 32'd0);
    chk(tag, "wb_alu", MEM_WB_ALU_result, 32'd0);
    chk(tag, "wb_data", MEM_WB_mem_data, 32'd0);
    chk(tag, "wb_ctl", 32'({MEM_WB_memtoreg, MEM_WB_regwrite, MEM_WB_rd}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    exp_t e;
    int k, d;

    //  txn: alu, rs2, f3, memread, memwrite, memtoreg, regwrite, rd, rdata
    //  exp: req, we, addr, wdata, be, misal, tmo, wb_alu, wb_data, wb_m2r, wb_rw, wb_rd
    vecs[0]  = '{"lw_0wait",  '{32'h100, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF}, 0,
                 '{1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 5'd3}};
    vecs[1]  = '{"lb_wait3",  '{32'h103, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h80FF1234}, 3,
                 '{1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0, 32'h103, 32'hFFFFFF80, 1'b1, 1'b1, 5'd4}};
    vecs[2]  = '{"lbu_wait3", '{32'h103, 32'h0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h80FF1234}, 3,
                 '{1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0, 32'h103, 32'h00000080, 1'b1, 1'b1, 5'd4}};
    vecs[3]  = '{"sh_202",    '{32'h202, 32'h0000ABCD, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0}, 0,
                 '{1'b1, 1'b1, 32'h200, 32'hABCDABCD, 4'hC, 1'b0, 1'b0, 32'h202, 32'h0, 1'b0, 1'b0, 5'd7}};
    vecs[4]  = '{"lw_misal",  '{32'h101, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h12345678}, 0,
                 '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0}};
    vecs[5]  = '{"add",       '{32'd7, 32'h99, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0}, 0,
                 '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'd7, 32'h0, 1'b0, 1'b1, 5'd5}};
    vecs[6]  = '{"lh_106",    '{32'h106, 32'h0, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h80017FFF}, 1,
                 '{1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 1'b0, 1'b0, 32'h106, 32'hFFFF8001, 1'b1, 1'b1, 5'd6}};
    vecs[7]  = '{"lhu_104",   '{32'h104, 32'h0, 3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h1234F00D}, 0,
                 '{1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 1'b0, 1'b0, 32'h104, 32'h0000F00D, 1'b1, 1'b1, 5'd8}};
    vecs[8]  = '{"sb_301",    '{32'h301, 32'h123456A5, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0}, 2,
                 '{1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 4'h2, 1'b0, 1'b0, 32'h301, 32'h0, 1'b0, 1'b0, 5'd9}};
    vecs[9]  = '{"sw_400",    '{32'h400, 32'hCAFEF00D, 3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0}, 1,
                 '{1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0, 5'd10}};
    vecs[10] = '{"sh_misal",  '{32'h203, 32'h5555, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 32'h0}, 0,
                 '{1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0}};
    vecs[11] = '{"lw_tmo",    '{32'h500, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h0}, 9,
                 '{1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0}};
    vecs[12] = '{"lw_lastack",'{32'h504, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h0BADCAFE}, TO + 1,
                 '{1'b1, 1'b0, 32'h504, 32'h0, 4'hF, 1'b0, 1'b0, 32'h504, 32'h0BADCAFE, 1'b1, 1'b1, 5'd11}};
    vecs[13] = '{"rd_and_wr", '{32'h600, 32'h11223344, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 32'hFFFFFFFF}, 0,
                 '{1'b1, 1'b1, 32'h600, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h600, 32'h0, 1'b1, 1'b0, 5'd12}};
    vecs[14] = '{"ld_f3_011", '{32'h700, 32'h0, 3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'h55AA55AA}, 0,
                 '{1'b1, 1'b0, 32'h700, 32'h0, 4'hF, 1'b0, 1'b0, 32'h700, 32'h55AA55AA, 1'b1, 1'b1, 5'd13}};
    vecs[15] = '{"sb_303",    '{32'h303, 32'h000000EE, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd14, 32'h0}, 0,
                 '{1'b1, 1'b1, 32'h300, 32'hEEEEEEEE, 4'h8, 1'b0, 1'b0, 32'h303, 32'h0, 1'b0, 1'b0, 5'd14}};
    vecs[16] = '{"lb_102",    '{32'h102, 32'h0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd15, 32'h00FE0000}, 2,
                 '{1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0, 32'h102, 32'hFFFFFFFE, 1'b1, 1'b1, 5'd15}};

    // reset state, with a load and ack presented that must be ignored
    #1 reset = 1'b1;
    drive(vecs[0].t);
    dmem_ack = 1'b1;
    #11;
    chk_quiet("reset");
    #5;
    chk_quiet("reset_edge");
    dmem_ack = 1'b0;
    drive(vecs[5].t);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_txn(vecs[i].tag, vecs[i].t, vecs[i].delay, vecs[i].e);

    // reset in the middle of a wait: request and stall drop without a clock
    run_txn("pre_rst_add", vecs[5].t, 0, vecs[5].e);
    drive(vecs[11].t);
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_wait", "req", 32'(dmem_req), 32'd1);
    chk("mid_wait", "stall", 32'(MEM_stall), 32'd1);
    reset = 1'b1;
    #1;
    chk_quiet("rst_async");
    @(posedge clk); #1;
    drive(vecs[5].t);
    #2 reset = 1'b0;
    run_txn("post_rst_add", vecs[5].t, 0, vecs[5].e);

    // randomized traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 3);
      t.alu   = $urandom;
      t.rs2   = $urandom;
      t.rdata = $urandom;
      t.rd    = 5'($urandom_range(0, 31));
      t.m2r   = 1'($urandom_range(0, 1));
      t.rw    = 1'($urandom_range(0, 1));
      t.rd_en = (k == 1) || (k == 3);
      t.wr    = (k >= 2);
      t.f3    = t.wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 7) == 0) ? 6 + $urandom_range(0, 3) : $urandom_range(0, TO + 1);
      e = model(t, d);
      run_txn($sformatf("rnd%0d", i), t, d, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Drives a single-port data-memory bus with a req/ack handshake and stalls the pipeline while an access is pending.
- Aligns load data, builds store byte-enables, and registers results into the MEM/WB pipeline register.

Parameters:
- TIMEOUT_CYCLES, 16, WAIT-state cycles without ack before the access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- EX_MEM_ALU_result  in  32  effective address (load/store) or ALU result
- EX_MEM_rs2_data  in  32  store data
- EX_MEM_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- EX_MEM_memread  in  1  load
- EX_MEM_memwrite  in  1  store
- EX_MEM_memtoreg  in  1  writeback selects memory data
- EX_MEM_regwrite  in  1  writeback enable
- EX_MEM_rd  in  5  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; rdata valid same cycle
- dmem_rdata  in  32  read word
- MEM_stall  out  1  hold IF..EX/MEM (EX/MEM register must not update while high)
- MEM_misaligned  out  1  one-cycle registered exception pulse
- MEM_bus_error  out  1  one-cycle registered timeout pulse
- MEM_WB_ALU_result  out  32
- MEM_WB_mem_data  out  32  aligned, extended load data
- MEM_WB_memtoreg  out  1
- MEM_WB_regwrite  out  1
- MEM_WB_rd  out  5

Behaviour:
- Reset (async, any state): FSM→IDLE, timeout counter→0. All registered outputs→0; dmem_req/MEM_stall→0 immediately.
- access = memread | memwrite. Both set → treated as store; memread ignored.
- Misaligned: h/hu/sh with addr[0]=1; w/sw with addr[1:0]≠0. No request issued; MEM_misaligned=1 next cycle; MEM/WB gets bubble (regwrite=0, rd=0, memtoreg=0, data=0); no stall.
- Unknown funct3 is treated as a word access.
- FSM IDLE:
  - aligned access → dmem_req=1 combinationally.
  - ack same cycle → zero-wait completion, MEM_stall=0.
  - else → WAIT, MEM_stall=1.
- FSM WAIT: dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be held stable; MEM_stall=1.
  - ack → IDLE, MEM_stall=0 that cycle, result registered at this edge.
  - counter reaches TIMEOUT_CYCLES → abort: req drops, IDLE, MEM_bus_error pulse, bubble to MEM/WB, MEM_stall=0.
- Counter: clears on entering WAIT, increments each WAIT cycle, width $clog2(TIMEOUT_CYCLES+1).
- While MEM_stall=1, MEM/WB loads a bubble each edge (NOP insertion).
- Store lanes:
  - sb: wdata={4{rs2[7:0]}}, be=0001<<addr[1:0].
  - sh: wdata={2{rs2[15:0]}}, be=0011<<(2*addr[1]).
  - sw: wdata=rs2, be=1111.
- Loads: be=1111, we=0. Extraction: byte lane addr[1:0] or half lane addr[1]; b/h sign-extend, bu/hu zero-extend, w passthrough.
- Non-memory instruction: passes to MEM/WB in one cycle with mem_data=0.
- Stores complete with regwrite forced to 0 in MEM/WB.
- Latency: one edge EX/MEM→MEM/WB for zero-wait; 1+N edges for N wait cycles.
- No new request is accepted in the abort/complete cycle except via the next EX/MEM value.

Decomposition:
- Package mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encoding (ST_IDLE, ST_WAIT), bubble constant.
- Sub-module mem_load_align: combinational funct3 + addr[1:0] + rdata → extended 32-bit data. Store lane/byte-enable logic stays inline.

Test Plan:
- lw addr 0x100, ack same cycle, rdata 0xDEADBEEF → no stall; next edge MEM_WB_mem_data=0xDEADBEEF, regwrite=1, memtoreg=1.
- lb addr 0x103, rdata 0x80FF1234, ack after 3 cycles → MEM_stall high 3 cycles; 3 bubbles in MEM/WB; then mem_data=0xFFFFFF80. Same with lbu → 0x00000080.
- sh addr 0x202, rs2 0x0000ABCD → dmem_be=1100, wdata=0xABCDABCD, addr=0x200, we=1; MEM_WB_regwrite=0.
- lw addr 0x101 → dmem_req never asserted; MEM_misaligned=1 for exactly one cycle; MEM/WB bubble.
- TIMEOUT_CYCLES=4, ack never arrives → MEM_stall high 4 WAIT cycles, MEM_bus_error pulse, dmem_req low, FSM back in IDLE.
- reset asserted mid-WAIT → dmem_req and MEM_stall drop without waiting for clk; all MEM_WB outputs 0; after release an add (regwrite=1, rd=5, result 7) reaches MEM/WB in one cycle.
